fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Host-side coefficient serializer that drives the `fir` block's serial coefficient-load port (`coeff_load_in`/`coeff_in`). It holds a parallel-writable shadow bank of `NCoeffs` signed coefficients (SFix<1,DataWidth-1>) and, on request, streams them bit-serially into the filter. The bit order is chosen so that the filter's coefficient shift register ends up holding exactly the shadow bank contents. It sits between the register/control interface and the `fir` instance.

## Interface
- `DataWidth`, 12: coefficient width in bits; must match the `fir` block's `DataWidth`.
- `NCoeffs`, 4: number of stored coefficients; must equal the `fir` block's `NTaps/2`.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `wr_en` input 1: shadow-bank write strobe.
- `wr_addr` input `$clog2(NCoeffs)`: shadow-bank index.
- `wr_data` input `DataWidth`: coefficient value to write.
- `load_req` input 1: single-cycle request to stream the bank into the filter.
- `fir_idle` input 1: high when the filter is not computing (no `start` pending, FSM idle).
- `busy` output 1: loader not in IDLE.
- `load_done` output 1: one-cycle pulse when streaming completes.
- `coeff_load_out` output 1: connects to the filter's `coeff_load_in`.
- `coeff_out` output 1: connects to the filter's `coeff_in`.

## Operation
- Shadow bank: `NCoeffs` × `DataWidth` registers, all 0 after reset.
  - A write lands at the edge where `wr_en`=1, `wr_addr`<NCoeffs and `busy`=0.
  - Writes with `busy`=1, or with `wr_addr`≥NCoeffs, are dropped.
- FSM states: IDLE, WAIT, SHIFT, DONE.
  - IDLE: on `load_req`=1, snapshot the bank into an internal `NCoeffs*DataWidth` shift register.
    - If `fir_idle`=1, go to SHIFT.
    - Otherwise go to WAIT.
  - WAIT: stay until `fir_idle`=1, then go to SHIFT.
  - SHIFT: emit one bit per cycle for exactly `NCoeffs*DataWidth` cycles, then go to DONE.
  - DONE: one cycle, then return to IDLE.
- Bit order: coefficient `NCoeffs-1` first, MSB first, down to coefficient 0, LSB last.
  - The filter shifts bits in at `coeffs[0][0]` and carries each word's MSB into the next word's LSB.
  - With this order, `coeffs[k]` equals `bank[k]` once the stream completes.
- Counters:
  - Bit counter runs 0..DataWidth-1 and wraps.
  - Word counter runs 0..NCoeffs-1; it increments on bit-counter wrap.
  - SHIFT exits when both counters are at their maximum.
- `load_req` in any state other than IDLE is ignored (no queuing).
- `load_req` and a valid `wr_en` in the same IDLE cycle: the write lands in the bank, but the snapshot takes the pre-write value.
- `fir_idle` falling during SHIFT is ignored; the stream completes. The system must keep the filter's `start` low while `busy`=1.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `load_done`=0, `coeff_load_out`=0, `coeff_out`=0, FSM in IDLE, counters 0, bank 0.
- Assertion of `rst_n`=0 mid-stream forces all outputs to 0 immediately. Streaming does not resume after release.
- Accept edge T: `load_req`=1 sampled in IDLE with `fir_idle`=1.
  - Cycles T+1 .. T+NCoeffs·DataWidth: `coeff_load_out`=1 and `coeff_out` = the current bit.
  - First streamed bit is `bank[NCoeffs-1][DataWidth-1]`.
- Cycle T+NCoeffs·DataWidth+1: `coeff_load_out`=0 and `load_done`=1 for exactly one cycle.
  - `busy`=1 from T+1 through this DONE cycle inclusive; `busy`=0 the cycle after.
- When WAIT is entered, each WAIT cycle shifts the above timeline by one.
  - The first bit appears the cycle after `fir_idle` is sampled high.
- Back-to-back: a `load_req` in the cycle after DONE is accepted normally.
- Streaming takes 48 cycles for the default parameters (4 × 12).
- `coeff_load_out` is contiguous; it never has a gap within one stream.

## Test plan
- Reset: hold `rst_n`=0, then release → all outputs 0; `load_req` with an all-zero bank → 48 zero bits, `load_done` at T+49.
- Bank = {0x400, 0x200, 0x100, 0x080} (index 0..3), `load_req` with `fir_idle`=1:
  - First 12 bits are 0x080 MSB-first (000010000000).
  - Last 12 bits are 0x400 MSB-first.
  - With a real `fir` attached, its `coeffs[0..3]` read 0x400, 0x200, 0x100, 0x080.
- `load_req` with `fir_idle`=0 for 5 cycles, then 1:
  - `busy`=1 throughout, `coeff_load_out` stays 0 during the wait.
  - First bit appears exactly one cycle after `fir_idle` rises.
- During SHIFT, `wr_en` to addr 2 with 0xFFF and a second `load_req`:
  - The stream is unchanged.
  - `bank[2]` is unchanged afterwards.
  - Only one `load_done` pulse occurs.
- Same-cycle `load_req` + write (addr 3, 0x7FF) in IDLE:
  - The stream carries the old `bank[3]`.
  - A following load carries 0x7FF first.
- `rst_n` pulsed low at bit 20 of a stream → `coeff_load_out`, `busy`, `load_done` drop asynchronously; the bank reads back as all 0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Serialises a parallel-written shadow bank of FIR coefficients into the filter's
// bit-serial coefficient-load port, last coefficient first and MSB first.
module fir_coeff_loader #(
  parameter int DataWidth = 12,
  parameter int NCoeffs   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(NCoeffs)-1:0] wr_addr,
  input  logic [DataWidth-1:0]       wr_data,
  input  logic                       load_req,
  input  logic                       fir_idle,
  output logic                       busy,
  output logic                       load_done,
  output logic                       coeff_load_out,
  output logic                       coeff_out
);

  localparam int AW     = $clog2(NCoeffs);
  localparam int BW     = $clog2(DataWidth);
  localparam int TotalW = DataWidth * NCoeffs;

  localparam logic [BW-1:0] BitMax  = BW'(DataWidth - 1);
  localparam logic [AW-1:0] WordMax = AW'(NCoeffs - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [DataWidth-1:0] bank_q [NCoeffs];
  logic [TotalW-1:0]    sreg_q;
  logic [TotalW-1:0]    snap_s;
  logic [BW-1:0]        bit_cnt_q;
  logic [AW-1:0]        word_cnt_q;
  logic                 busy_q;
  logic                 load_done_q;
  logic                 coeff_load_q;
  logic                 coeff_q;
  logic                 wr_ok_s;

  assign busy           = busy_q;
  assign load_done      = load_done_q;
  assign coeff_load_out = coeff_load_q;
  assign coeff_out      = coeff_q;

  assign wr_ok_s = wr_en && !busy_q && (32'(wr_addr) < 32'(NCoeffs));

  // Flatten the bank so that bank[NCoeffs-1] MSB sits at the top of the stream.
  always_comb begin
    snap_s = '0;
    for (int k = 0; k < NCoeffs; k++) begin
      snap_s[k*DataWidth +: DataWidth] = bank_q[k];
    end
  end

  // Shadow bank; writes only land while the loader is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCoeffs; k++) begin
        bank_q[k] <= '0;
      end
    end else if (wr_ok_s) begin
      bank_q[wr_addr] <= wr_data;
    end
  end

  // Loader FSM with registered outputs; the first bit is presented on SHIFT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      busy_q       <= 1'b0;
      load_done_q  <= 1'b0;
      coeff_load_q <= 1'b0;
      coeff_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load_done_q <= 1'b0;
          bit_cnt_q   <= '0;
          word_cnt_q  <= '0;
          if (load_req) begin
            busy_q <= 1'b1;
            if (fir_idle) begin
              state_q      <= ST_SHIFT;
              coeff_load_q <= 1'b1;
              coeff_q      <= snap_s[TotalW-1];
              sreg_q       <= {snap_s[TotalW-2:0], 1'b0};
            end else begin
              state_q      <= ST_WAIT;
              coeff_load_q <= 1'b0;
              coeff_q      <= 1'b0;
              sreg_q       <= snap_s;
            end
          end else begin
            busy_q       <= 1'b0;
            coeff_load_q <= 1'b0;
            coeff_q      <= 1'b0;
          end
        end

        ST_WAIT: begin
          busy_q <= 1'b1;
          if (fir_idle) begin
            state_q      <= ST_SHIFT;
            coeff_load_q <= 1'b1;
            coeff_q      <= sreg_q[TotalW-1];
            sreg_q       <= {sreg_q[TotalW-2:0], 1'b0};
          end else begin
            coeff_load_q <= 1'b0;
            coeff_q      <= 1'b0;
          end
        end

        ST_SHIFT: begin
          busy_q <= 1'b1;
          if ((bit_cnt_q == BitMax) && (word_cnt_q == WordMax)) begin
            state_q      <= ST_DONE;
            coeff_load_q <= 1'b0;
            coeff_q      <= 1'b0;
            load_done_q  <= 1'b1;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
          end else begin
            if (bit_cnt_q == BitMax) begin
              bit_cnt_q  <= '0;
              word_cnt_q <= word_cnt_q + AW'(1);
            end else begin
              bit_cnt_q  <= bit_cnt_q + BW'(1);
            end
            coeff_load_q <= 1'b1;
            coeff_q      <= sreg_q[TotalW-1];
            sreg_q       <= {sreg_q[TotalW-2:0], 1'b0};
          end
        end

        ST_DONE: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          load_done_q  <= 1'b0;
          coeff_load_q <= 1'b0;
          coeff_q      <= 1'b0;
        end

        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          load_done_q  <= 1'b0;
          coeff_load_q <= 1'b0;
          coeff_q      <= 1'b0;
          bit_cnt_q    <= '0;
          word_cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: a queue-based stream model checked every
// cycle, plus literal expectations on captured streams and timing.
module tb_fir_coeff_loader;

  localparam int DW = 12;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_addr = 2'd0;
  logic [DW-1:0] wr_data = 12'd0;
  logic          load_req = 1'b0;
  logic          fir_idle = 1'b1;
  logic          busy, load_done, coeff_load_out, coeff_out;

  fir_coeff_loader #(.DataWidth(DW), .NCoeffs(NC)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_req(load_req), .fir_idle(fir_idle), .busy(busy), .load_done(load_done),
    .coeff_load_out(coeff_load_out), .coeff_out(coeff_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: bank contents plus the queue of bits still owed to the filter.
  logic [DW-1:0] m_bank [NC];
  bit            m_q [$];
  bit            m_wait = 1'b0;
  bit            e_busy = 1'b0, e_done = 1'b0, e_cload = 1'b0, e_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) m_bank[k] <= 12'd0;
      m_q.delete();
      m_wait  <= 1'b0;
      e_busy  <= 1'b0;
      e_done  <= 1'b0;
      e_cload <= 1'b0;
      e_cout  <= 1'b0;
    end else begin
      if (e_done) begin
        e_done <= 1'b0;
        e_busy <= 1'b0;
      end else if (!e_busy) begin
        if (load_req) begin
          m_q.delete();
          for (int k = NC - 1; k >= 0; k--)
            for (int b = DW - 1; b >= 0; b--) m_q.push_back(m_bank[k][b]);
          e_busy <= 1'b1;
          m_wait <= !fir_idle;
          if (fir_idle) begin
            e_cload <= 1'b1;
            e_cout  <= m_q.pop_front();
          end
        end
      end else if (m_wait) begin
        if (fir_idle) begin
          m_wait  <= 1'b0;
          e_cload <= 1'b1;
          e_cout  <= m_q.pop_front();
        end
      end else if (m_q.size() > 0) begin
        e_cout <= m_q.pop_front();
      end else begin
        e_cload <= 1'b0;
        e_cout  <= 1'b0;
        e_done  <= 1'b1;
      end
      if (wr_en && !e_busy && (int'(wr_addr) < NC)) m_bank[wr_addr] <= wr_data;
    end
  end

  int          cyc = 0;
  int          ncap = 0;
  int          first_cyc = 0, done_cyc = 0, req_cyc = 0, done_cnt = 0;
  bit          done_seen = 1'b0;
  logic [47:0] cap = 48'd0;

  // Per-cycle compare against the model, plus stream capture for literal checks.
  always @(negedge clk) begin
    cyc++;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("load_done", 64'(load_done), 64'(e_done));
    chk("coeff_load_out", 64'(coeff_load_out), 64'(e_cload));
    if (e_cload) chk("coeff_out", 64'(coeff_out), 64'(e_cout));
    if (coeff_load_out) begin
      if (ncap == 0) first_cyc = cyc;
      cap = {cap[46:0], coeff_out};
      ncap++;
    end
    if (load_done) begin
      done_seen = 1'b1;
      done_cnt++;
      done_cyc = cyc;
    end
    if (load_req && !e_busy) req_cyc = cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap = 48'd0; ncap = 0; done_seen = 1'b0; done_cnt = 0;
  endtask

  task automatic do_load(input logic idle);
    clear_cap();
    load_req = 1'b1; fir_idle = idle;
    tick(1);
    load_req = 1'b0;
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done_seen && i < 300) begin tick(1); i++; end
    chk("done_timeout", 64'(done_seen), 64'd1);
  endtask

  task automatic write(input logic [1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  int rise_cyc;

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cload", 64'(coeff_load_out), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);

    // All-zero bank stream
    do_load(1'b1);
    wait_done();
    chk("zero_stream", 64'(cap), 64'd0);
    chk("zero_nbits", 64'(ncap), 64'd48);
    chk("zero_first_lat", 64'(first_cyc - req_cyc), 64'd1);
    chk("zero_done_lat", 64'(done_cyc - req_cyc), 64'd49);

    // Distinct bank pattern
    write(2'd0, 12'h400); write(2'd1, 12'h200); write(2'd2, 12'h100); write(2'd3, 12'h080);
    do_load(1'b1);
    wait_done();
    chk("pat_first_word", 64'(cap[47:36]), 64'h080);
    chk("pat_last_word", 64'(cap[11:0]), 64'h400);
    chk("pat_stream", 64'(cap), 64'h080_100_200_400);

    // Delayed start: filter busy for 5 cycles
    do_load(1'b0);
    tick(4);
    chk("wait_no_bits", 64'(ncap), 64'd0);
    fir_idle = 1'b1;
    rise_cyc = cyc + 1;
    wait_done();
    chk("wait_first_lat", 64'(first_cyc - rise_cyc), 64'd1);
    chk("wait_len", 64'(done_cyc - first_cyc), 64'd48);
    chk("wait_stream", 64'(cap), 64'h080_100_200_400);

    // Write and load request during SHIFT are dropped
    do_load(1'b1);
    tick(10);
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 12'hFFF; load_req = 1'b1;
    tick(1);
    wr_en = 1'b0; load_req = 1'b0;
    wait_done();
    tick(10);
    chk("shift_stream", 64'(cap), 64'h080_100_200_400);
    chk("shift_one_done", 64'(done_cnt), 64'd1);
    do_load(1'b1);
    wait_done();
    chk("bank2_kept", 64'(cap[35:24]), 64'h100);

    // Same-cycle load and write: snapshot takes the old value
    clear_cap();
    load_req = 1'b1; fir_idle = 1'b1; wr_en = 1'b1; wr_addr = 2'd3; wr_data = 12'h7FF;
    tick(1);
    load_req = 1'b0; wr_en = 1'b0;
    wait_done();
    chk("same_old_word", 64'(cap[47:36]), 64'h080);
    do_load(1'b1);
    wait_done();
    chk("same_new_word", 64'(cap[47:36]), 64'h7FF);
    chk("same_new_stream", 64'(cap), 64'h7FF_100_200_400);

    // Asynchronous reset in the middle of a stream
    do_load(1'b1);
    begin
      int i = 0;
      while (ncap < 20 && i < 100) begin tick(1); i++; end
    end
    chk("mid_bits", 64'(ncap), 64'd20);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cload", 64'(coeff_load_out), 64'd0);
    chk("arst_done", 64'(load_done), 64'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("no_resume", 64'(busy), 64'd0);
    do_load(1'b1);
    wait_done();
    chk("bank_cleared", 64'(cap), 64'd0);
    chk("bank_cleared_n", 64'(ncap), 64'd48);

    tick(3);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
